// File: rtl/dcache_dm_burst_if.sv
// Core-side request/response and backing-memory bus of the burst data cache.
// slave  : cache view (accepts core requests, issues memory requests)
// master : environment view (core driver plus memory responder)
interface dcache_dm_burst_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // core request / response
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_byte_enable;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    // line refill channel
    logic                  mem_rd_req;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  mem_rd_ready;
    logic                  mem_rd_valid;
    logic [31:0]           mem_rd_data;
    // write-through channel
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [31:0]           mem_wr_data;
    logic [3:0]            mem_wr_be;
    logic                  mem_wr_ack;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_byte_enable,
        input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_byte_enable,
        output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be
    );
endinterface

// File: rtl/dcache_dm_burst.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst refill.
// Ports: clk, rst_n (async, active-low); bus (dcache_dm_burst_if.slave: core
// request/response plus refill and write-through channels); cache_invalidate
// (clears all valid bits, deferred while busy); hit_count / miss_count (load
// hit and miss counters, wrap modulo 2^32).
module dcache_dm_burst #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_dm_burst_if.slave     bus,
    input  logic                 cache_invalidate,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = ADDR_WIDTH - 2 - WORD_W - IDX_W;
    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned DEPTH  = NUM_LINES * WORDS_PER_LINE;

    typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_DATA, WR_WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [WORD_W-1:0]       req_word_q, req_word_d;
    logic [IDX_W-1:0]        req_idx_q, req_idx_d;
    logic [TAG_W-1:0]        req_tag_q, req_tag_d;
    logic [WORD_W-1:0]       beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic [31:0]             hit_d, miss_d;

    logic                    rsp_valid_d, rsp_err_d;
    logic [31:0]             rsp_rdata_d;
    logic                    mem_rd_req_d, mem_wr_req_d;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr_d, mem_wr_addr_d;
    logic [31:0]             mem_wr_data_d;
    logic [3:0]              mem_wr_be_d;

    // storage arrays are not reset; only valid bits qualify them
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
    logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
    logic                    dwr_en, tag_we;
    logic [IDX_W-1:0]        dwr_idx;
    logic [WORD_W-1:0]       dwr_word;
    logic [DATA_WIDTH-1:0]   dwr_data;

    // lookup of the presented request address
    logic [WORD_W-1:0]       lk_word;
    logic [IDX_W-1:0]        lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    lk_hit;
    logic [DATA_WIDTH-1:0]   lk_data;
    logic [DATA_WIDTH-1:0]   st_merged;

    assign lk_word = bus.req_addr[2 +: WORD_W];
    assign lk_idx  = bus.req_addr[2 + WORD_W +: IDX_W];
    assign lk_tag  = bus.req_addr[2 + WORD_W + IDX_W +: TAG_W];
    assign lk_hit  = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_data = data_mem[{lk_idx, lk_word}];

    // ready depends on the live invalidate so a same-cycle request is refused
    assign bus.req_ready = (state_q == IDLE) && !pend_q && !cache_invalidate;

    // store-hit byte merge into the cached word
    always_comb begin
        st_merged = lk_data;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (bus.req_byte_enable[b]) st_merged[8*b +: 8] = bus.req_wdata[8*b +: 8];
        end
    end

    // next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        valid_d       = valid_q;
        req_word_d    = req_word_q;
        req_idx_d     = req_idx_q;
        req_tag_d     = req_tag_q;
        beat_d        = beat_q;
        cap_d         = cap_q;
        hit_d         = hit_count;
        miss_d        = miss_count;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = 32'd0;
        mem_rd_req_d  = bus.mem_rd_req;
        mem_rd_addr_d = bus.mem_rd_addr;
        mem_wr_req_d  = bus.mem_wr_req;
        mem_wr_addr_d = bus.mem_wr_addr;
        mem_wr_data_d = bus.mem_wr_data;
        mem_wr_be_d   = bus.mem_wr_be;
        dwr_en        = 1'b0;
        tag_we        = 1'b0;
        dwr_idx       = lk_idx;
        dwr_word      = lk_word;
        dwr_data      = st_merged;

        if (cache_invalidate && (state_q != IDLE)) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_q || cache_invalidate) begin
                    valid_d = '0;
                    pend_d  = 1'b0;
                end else if (bus.req_valid) begin
                    req_word_d = lk_word;
                    req_idx_d  = lk_idx;
                    req_tag_d  = lk_tag;
                    if (bus.req_addr[1:0] != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        state_d       = WR_WAIT;
                        mem_wr_req_d  = 1'b1;
                        mem_wr_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wr_data_d = bus.req_wdata;
                        mem_wr_be_d   = bus.req_byte_enable;
                        dwr_en        = lk_hit;
                    end else if (lk_hit) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lk_data;
                        hit_d       = hit_count + 32'd1;
                    end else begin
                        state_d       = REFILL_REQ;
                        miss_d        = miss_count + 32'd1;
                        mem_rd_req_d  = 1'b1;
                        mem_rd_addr_d = {lk_tag, lk_idx, {(WORD_W + 2){1'b0}}};
                        beat_d        = '0;
                    end
                end
            end
            REFILL_REQ: begin
                if (bus.mem_rd_ready) begin
                    state_d       = REFILL_DATA;
                    mem_rd_req_d  = 1'b0;
                    mem_rd_addr_d = '0;
                end
            end
            REFILL_DATA: begin
                if (bus.mem_rd_valid) begin
                    dwr_en   = 1'b1;
                    dwr_idx  = req_idx_q;
                    dwr_word = beat_q;
                    dwr_data = bus.mem_rd_data;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == req_word_q) cap_d = bus.mem_rd_data;
                    if (beat_q == WORD_W'(WORDS_PER_LINE - 1)) begin
                        valid_d[req_idx_q] = 1'b1;
                        tag_we             = 1'b1;
                        state_d            = RESP;
                        rsp_valid_d        = 1'b1;
                        // requested word may be this very beat
                        rsp_rdata_d = (beat_q == req_word_q) ? bus.mem_rd_data : cap_q;
                    end
                end
            end
            WR_WAIT: begin
                if (bus.mem_wr_ack) begin
                    mem_wr_req_d = 1'b0;
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pend_q          <= 1'b0;
            valid_q         <= '0;
            req_word_q      <= '0;
            req_idx_q       <= '0;
            req_tag_q       <= '0;
            beat_q          <= '0;
            cap_q           <= '0;
            hit_count       <= 32'd0;
            miss_count      <= 32'd0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= 32'd0;
            bus.mem_rd_req  <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.mem_wr_req  <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= 32'd0;
            bus.mem_wr_be   <= 4'd0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            valid_q         <= valid_d;
            req_word_q      <= req_word_d;
            req_idx_q       <= req_idx_d;
            req_tag_q       <= req_tag_d;
            beat_q          <= beat_d;
            cap_q           <= cap_d;
            hit_count       <= hit_d;
            miss_count      <= miss_d;
            bus.rsp_valid   <= rsp_valid_d;
            bus.rsp_err     <= rsp_err_d;
            bus.rsp_rdata   <= rsp_rdata_d;
            bus.mem_rd_req  <= mem_rd_req_d;
            bus.mem_rd_addr <= mem_rd_addr_d;
            bus.mem_wr_req  <= mem_wr_req_d;
            bus.mem_wr_addr <= mem_wr_addr_d;
            bus.mem_wr_data <= mem_wr_data_d;
            bus.mem_wr_be   <= mem_wr_be_d;
        end
    end

    // data and tag arrays
    always_ff @(posedge clk) begin
        if (dwr_en) data_mem[{dwr_idx, dwr_word}] <= dwr_data;
        if (tag_we) tag_mem[req_idx_q] <= req_tag_q;
    end
endmodule

// File: tb/tb_dcache_dm_burst.sv
// Self-checking bench for dcache_dm_burst: directed vector table, hand-written
// invalidate/reset sequences and randomized traffic against a line-presence model.
module tb_dcache_dm_burst;
    localparam int unsigned NL  = 16;
    localparam int unsigned WPL = 4;

    logic        clk;
    logic        rst_n;
    logic        cache_invalidate;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_dm_burst_if #(.ADDR_WIDTH(32)) bus ();

    dcache_dm_burst #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(NL), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .cache_invalidate(cache_invalidate),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // backing memory and cache-presence model
    logic [31:0] mem_model [logic [31:0]];
    bit          mv   [NL];
    logic [31:0] mres [NL];
    logic [31:0] mh, mm;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_dly;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_rd;
        bit          exp_wr;
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37) ^ 32'hC3C3_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_inv();
        for (int i = 0; i < int'(NL); i++) mv[i] = 1'b0;
    endtask

    // expected outcome of one request, advancing the model
    task automatic model_apply(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rdata,
                               output bit err, output bit rd, output bit wrq);
        int          idx;
        logic [31:0] base;
        idx   = int'((addr >> 4) % NL);
        base  = addr & 32'hFFFF_FFF0;
        rdata = 32'd0; err = 1'b0; rd = 1'b0; wrq = 1'b0;
        if (addr % 4 != 0) begin
            err = 1'b1;
        end else if (wr) begin
            wrq = 1'b1;
            mem_model[addr] = merge(mem_rd(addr), wdata, be);
        end else begin
            rdata = mem_rd(addr);
            if (mv[idx] && mres[idx] == base) begin
                mh = mh + 1;
            end else begin
                mm = mm + 1;
                rd = 1'b1;
                mv[idx] = 1'b1;
                mres[idx] = base;
            end
        end
    endtask

    task automatic chk_zero_outputs(input string where);
        chk($sformatf("%s rsp_valid", where),   32'(bus.rsp_valid), 0);
        chk($sformatf("%s rsp_rdata", where),   bus.rsp_rdata, 0);
        chk($sformatf("%s rsp_err", where),     32'(bus.rsp_err), 0);
        chk($sformatf("%s mem_rd_req", where),  32'(bus.mem_rd_req), 0);
        chk($sformatf("%s mem_rd_addr", where), bus.mem_rd_addr, 0);
        chk($sformatf("%s mem_wr_req", where),  32'(bus.mem_wr_req), 0);
        chk($sformatf("%s mem_wr_addr", where), bus.mem_wr_addr, 0);
        chk($sformatf("%s mem_wr_data", where), bus.mem_wr_data, 0);
        chk($sformatf("%s mem_wr_be", where),   32'(bus.mem_wr_be), 0);
        chk($sformatf("%s hit_count", where),   hit_count, 0);
        chk($sformatf("%s miss_count", where),  miss_count, 0);
    endtask

    // one core transaction with the memory responder; called and returning at a negedge
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int ack_dly_in, input int inv_beat,
                          input int rst_beats, output logic [31:0] rdata, output bit err,
                          output bit saw_rd, output bit saw_wr, output bit got);
        int          beats, lat, last_beat_cyc, ack_cyc, wr_wait, ack_dly;
        bit          rd_addr_chk, wr_chk;
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        beats = 0; lat = 0; last_beat_cyc = -1; ack_cyc = -1; wr_wait = 0;
        rd_addr_chk = 1'b0; wr_chk = 1'b0;
        ack_dly = (ack_dly_in < 0) ? int'($urandom_range(0, 4)) : ack_dly_in;
        rdata = 32'd0; err = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; got = 1'b0;

        for (int w = 0; w < 20 && !bus.req_ready; w++) @(negedge clk);
        if (!bus.req_ready) begin
            chk("req_ready timeout", 32'(bus.req_ready), 1);
            return;
        end
        bus.req_valid       = 1'b1;
        bus.req_write       = wr;
        bus.req_addr        = addr;
        bus.req_wdata       = wdata;
        bus.req_byte_enable = be;

        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus.req_valid = 1'b0;
            bus.mem_rd_ready = 1'b0;
            bus.mem_rd_valid = 1'b0;
            bus.mem_wr_ack   = 1'b0;
            cache_invalidate = 1'b0;
            if (rst_beats > 0 && beats == rst_beats) begin
                rst_n = 1'b0;
                #1;
                chk_zero_outputs("mid-refill reset");
                return;
            end
            if (bus.rsp_valid) begin
                rdata = bus.rsp_rdata;
                err   = bus.rsp_err;
                lat   = cyc;
                got   = 1'b1;
                break;
            end
            if (bus.mem_rd_req) begin
                saw_rd = 1'b1;
                if (!rd_addr_chk) begin
                    chk("mem_rd_addr", bus.mem_rd_addr, base);
                    rd_addr_chk = 1'b1;
                end
                if ($urandom_range(0, 2) != 0) bus.mem_rd_ready = 1'b1;
            end else if (saw_rd && beats < int'(WPL)) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = mem_rd(base + 32'(4 * beats));
                    if (beats == inv_beat) cache_invalidate = 1'b1;
                    if (beats == int'(WPL) - 1) last_beat_cyc = cyc;
                    beats++;
                end
            end
            if (bus.mem_wr_req) begin
                saw_wr = 1'b1;
                if (!wr_chk) begin
                    chk("mem_wr_addr", bus.mem_wr_addr, addr & 32'hFFFF_FFFC);
                    chk("mem_wr_data", bus.mem_wr_data, wdata);
                    chk("mem_wr_be", 32'(bus.mem_wr_be), 32'(be));
                    wr_chk = 1'b1;
                end
                if (wr_wait >= ack_dly) begin
                    bus.mem_wr_ack = 1'b1;
                    ack_cyc = cyc;
                end else begin
                    wr_wait++;
                end
            end
        end
        if (!got) begin
            chk("response timeout", 32'(got), 1);
            return;
        end
        chk("response latency", 32'(lat),
            32'(saw_rd ? last_beat_cyc + 1 : (saw_wr ? ack_cyc + 1 : 0)));
        @(negedge clk);
        chk("rsp_valid single pulse", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        logic [31:0] rdata, e_rdata;
        bit          err, saw_rd, saw_wr, got, e_err, e_rd, e_wr, wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        int          inv_beat;

        vecs[0] = '{0, 32'h40,   32'h0,        4'h0, -1, 32'h0000_00A0, 0, 1, 0, 0, 1};
        vecs[1] = '{0, 32'h48,   32'h0,        4'h0, -1, 32'h0000_00A2, 0, 0, 0, 1, 1};
        vecs[2] = '{1, 32'h44,   32'h1122_3344, 4'h3, 3, 32'h0,         0, 0, 1, 1, 1};
        vecs[3] = '{0, 32'h44,   32'h0,        4'h0, -1, 32'h0000_3344, 0, 0, 0, 2, 1};
        vecs[4] = '{1, 32'h1000, 32'hCAFE_F00D, 4'hF, -1, 32'h0,        0, 0, 1, 2, 1};
        vecs[5] = '{0, 32'h1000, 32'h0,        4'h0, -1, 32'hCAFE_F00D, 0, 1, 0, 2, 2};
        vecs[6] = '{0, 32'h42,   32'h0,        4'h0, -1, 32'h0,         1, 0, 0, 2, 2};

        mem_model[32'h40] = 32'hA0;
        mem_model[32'h44] = 32'hA1;
        mem_model[32'h48] = 32'hA2;
        mem_model[32'h4C] = 32'hA3;
        model_inv();
        mh = 0; mm = 0;

        rst_n = 1'b0;
        cache_invalidate = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_byte_enable = '0;
        bus.mem_rd_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
        bus.mem_wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready after reset", 32'(bus.req_ready), 1);

        // directed vector table
        for (int i = 0; i < 7; i++) begin
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                        e_rdata, e_err, e_rd, e_wr);
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].ack_dly,
                   -1, -1, rdata, err, saw_rd, saw_wr, got);
            chk($sformatf("vec%0d rsp_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d rsp_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d refill issued", i), 32'(saw_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d write issued", i), 32'(saw_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d hit_count", i), hit_count, vecs[i].exp_hits);
            chk($sformatf("vec%0d miss_count", i), miss_count, vecs[i].exp_miss);
        end

        // invalidate during a refill: response still correct, line then gone
        model_apply(0, 32'h80, 0, 0, e_rdata, e_err, e_rd, e_wr);
        do_req(0, 32'h80, 0, 0, -1, 1, -1, rdata, err, saw_rd, saw_wr, got);
        model_inv();
        chk("inv-refill rdata", rdata, e_rdata);
        chk("inv-refill refill issued", 32'(saw_rd), 1);
        model_apply(0, 32'h84, 0, 0, e_rdata, e_err, e_rd, e_wr);
        do_req(0, 32'h84, 0, 0, -1, -1, -1, rdata, err, saw_rd, saw_wr, got);
        chk("after inv refill issued", 32'(saw_rd), 32'(e_rd));
        chk("after inv miss_count", miss_count, mm);

        // request coinciding with invalidate in IDLE is refused
        model_apply(0, 32'h84, 0, 0, e_rdata, e_err, e_rd, e_wr);
        chk("line resident before idle inv", 32'(e_rd), 0);
        @(negedge clk);
        cache_invalidate = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h84;
        #1;
        chk("req_ready with invalidate", 32'(bus.req_ready), 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cache_invalidate = 1'b0;
        chk("refused req rsp_valid", 32'(bus.rsp_valid), 0);
        mh = mh - 1;  // the probe above was not a real access
        model_inv();
        model_apply(0, 32'h84, 0, 0, e_rdata, e_err, e_rd, e_wr);
        do_req(0, 32'h84, 0, 0, -1, -1, -1, rdata, err, saw_rd, saw_wr, got);
        chk("after idle inv refill issued", 32'(saw_rd), 1);
        chk("after idle inv rdata", rdata, e_rdata);
        chk("after idle inv hit_count", hit_count, mh);
        chk("after idle inv miss_count", miss_count, mm);

        // reset after two refill beats; stray beats afterwards are ignored
        do_req(0, 32'hC0, 0, 0, -1, -1, 2, rdata, err, saw_rd, saw_wr, got);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_inv();
        mh = 0; mm = 0;
        for (int k = 0; k < 2; k++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 32'hDEAD_0000 + 32'(k);
            @(negedge clk);
            chk("stray beat rsp_valid", 32'(bus.rsp_valid), 0);
        end
        bus.mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("stray beat rsp_valid", 32'(bus.rsp_valid), 0);
        chk("after reset miss_count", miss_count, 0);
        model_apply(0, 32'hC0, 0, 0, e_rdata, e_err, e_rd, e_wr);
        do_req(0, 32'hC0, 0, 0, -1, -1, -1, rdata, err, saw_rd, saw_wr, got);
        chk("after reset refill issued", 32'(saw_rd), 1);
        chk("after reset rdata", rdata, e_rdata);
        chk("after reset miss_count", miss_count, 1);

        // randomized traffic against the model
        for (int t = 0; t < 200; t++) begin
            addr = 32'($urandom_range(0, 511)) * 32'd4;
            if ($urandom_range(0, 15) == 0) addr = addr + 32'($urandom_range(1, 3));
            wr    = ($urandom_range(0, 2) == 0);
            wdata = $urandom;
            be    = 4'($urandom);
            inv_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 19) == 0) begin
                cache_invalidate = 1'b1;
                @(negedge clk);
                cache_invalidate = 1'b0;
                model_inv();
            end
            model_apply(wr, addr, wdata, be, e_rdata, e_err, e_rd, e_wr);
            do_req(wr, addr, wdata, be, -1, inv_beat, -1, rdata, err, saw_rd, saw_wr, got);
            if (saw_rd && inv_beat >= 0) model_inv();
            chk($sformatf("rand%0d rsp_rdata @%08h", t, addr), rdata, e_rdata);
            chk($sformatf("rand%0d rsp_err", t), 32'(err), 32'(e_err));
            chk($sformatf("rand%0d refill issued", t), 32'(saw_rd), 32'(e_rd));
            chk($sformatf("rand%0d write issued", t), 32'(saw_wr), 32'(e_wr));
            chk($sformatf("rand%0d hit_count", t), hit_count, mh);
            chk($sformatf("rand%0d miss_count", t), miss_count, mm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_dm_burst.md
Name: dcache_dm_burst

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache with multi-word lines.
- Sits between the core data port and a burst-capable backing memory.
- Generalises the single-entry data buffer into NUM_LINES lines of WORDS_PER_LINE words, filled by burst refill.
- Adds misalignment error reporting and hit/miss counters.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: word width; must be 32.
- NUM_LINES, 16: number of cache lines; power of 2, ≥2.
- WORDS_PER_LINE, 4: burst length and line size in words; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  1  core request.
- req_ready  out  1  cache can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data.
- req_byte_enable  in  4  store byte lanes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data.
- rsp_err  out  1  misaligned access, valid with rsp_valid.
- mem_rd_req  out  1  line refill request.
- mem_rd_addr  out  ADDR_WIDTH  line-aligned refill address.
- mem_rd_ready  in  1  memory accepts the refill request.
- mem_rd_valid  in  1  refill beat valid.
- mem_rd_data  in  32  refill beat data, in ascending word order.
- mem_wr_req  out  1  write-through request.
- mem_wr_addr  out  ADDR_WIDTH  word-aligned store address.
- mem_wr_data  out  32  store data.
- mem_wr_be  out  4  store byte lanes.
- mem_wr_ack  in  1  write completed.
- cache_invalidate  in  1  clear all valid bits.
- hit_count  out  32  load hits.
- miss_count  out  32  load misses.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Address split: offset = addr[1:0]; word = next log2(WORDS_PER_LINE) bits; index = next log2(NUM_LINES) bits; tag = remaining bits.
- Reset: all outputs 0; all valid bits 0; counters 0; FSM in IDLE. Data array contents are not reset.
- States: IDLE, REFILL_REQ, REFILL_DATA, WR_WAIT, RESP.
- req_ready = 1 only in IDLE with no pending invalidate.
- Handshake: a request is accepted on the cycle with req_valid && req_ready (cycle N). Its request fields are registered at acceptance.
- Misaligned (addr[1:0] != 0):
  - No memory traffic and no counter change.
  - Go to RESP; rsp_valid = 1 and rsp_err = 1 at N+1, rsp_rdata = 0.
- Load hit (valid && tag match):
  - rsp_valid = 1 with the requested word at N+1; hit_count += 1.
- Load miss:
  - miss_count += 1; enter REFILL_REQ at N+1.
  - mem_rd_req held high with mem_rd_addr = line base until a cycle with mem_rd_ready = 1, then REFILL_DATA.
  - Each mem_rd_valid writes the next word; the beat counter wraps at WORDS_PER_LINE.
  - On the last beat (cycle M): write the tag and set valid. rsp_valid at M+1 carries the requested word, taken from the captured beat (bypass).
  - Gaps in mem_rd_valid are legal.
- Store:
  - Go to WR_WAIT. mem_wr_req held high with address/data/byte enables until mem_wr_ack.
  - If the store hits, update only the enabled bytes of the cached word at acceptance.
  - If the store misses, cache state is unchanged (no allocate).
  - rsp_valid (rsp_rdata = 0) on the cycle after mem_wr_ack.
  - A zero byte enable is still forwarded.
- RESP lasts one cycle, then IDLE. rsp_valid is never high for more than one cycle; there is no response backpressure.
- cache_invalidate:
  - Sampled every cycle. In IDLE, all valid bits clear on the next edge.
  - If asserted while busy, it is latched as pending and applied on return to IDLE, before the next request is accepted.
  - An in-flight refill still completes and responds. Its line is then invalidated by the pending invalidate.
- A request in IDLE in the same cycle as cache_invalidate is not accepted, because req_ready = 0 that cycle.
- Counters wrap modulo 2^32.
- Reset asserted mid-refill or mid-write: immediate return to IDLE, valid bits cleared, memory request outputs dropped. Remaining beats arriving after reset release are ignored, because the FSM is not in REFILL_DATA.

Test Plan:
- Reset, then load 0x40 with memory beats 0xA0, 0xA1, 0xA2, 0xA3 → mem_rd_req with mem_rd_addr = 0x40; rsp_rdata = 0xA0 one cycle after the last beat; miss_count = 1.
- Load 0x48 after the previous scenario → rsp_valid at N+1, rsp_rdata = 0xA2, no mem_rd_req, hit_count = 1.
- Store to 0x44 with wdata 0x11223344, byte_enable 4'b0011, mem_wr_ack delayed 3 cycles → mem_wr_be = 0011; response the cycle after ack; a following load of 0x44 returns 0x00003344 | (0xA1 & 0xFFFF0000) with no refill.
- Store miss to 0x1000, then load 0x1000 → the store produces no refill; the load misses (miss_count += 1).
- Load at 0x42 → rsp_err = 1 at N+1; no memory request; counters unchanged.
- Assert cache_invalidate during a refill → refill response delivered; the next load of the same line misses. Separately, assert rst_n low after 2 beats → all outputs 0; a subsequent load of that address misses.
